ps2_cmd_sequencer: RTL

- Host-to-device command controller for the PS2 keyboard port.
- Accepts a command byte with an optional argument byte from the SMC register logic (SEND_PS2_KBD_CMD), drives the ps2_port TX interface and waits for the device response.
- Handles ACK/RESEND/timeout with bounded retries and reports a status byte for READ_PS2_KBD_STAT.
- Splits the ps2_port RX stream: command responses are consumed here; all other bytes pass through to the keyboard scan-code FIFO.

---
 rtl/ps2_cmd_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_cmd_sequencer.sv
// Host-to-device PS2 keyboard command sequencer: sends a command (and optional
// argument) through ps2_port, handles ACK/RESEND/timeout and splits the RX stream.
module ps2_cmd_sequencer #(
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned TIMEOUT_US = 20000,
  parameter int unsigned TOW        = 15
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       ck1us,
  input  logic [7:0] cmd_i,
  input  logic [7:0] arg_i,
  input  logic       has_arg_i,
  input  logic       cmd_v_i,
  output logic       cmd_busy_o,
  output logic [7:0] status_o,
  output logic       status_v_o,
  output logic [7:0] ptx_code_o,
  output logic       ptx_v_o,
  input  logic       pbusy_i,
  input  logic       ptx_acked_i,
  input  logic       ptx_errd_i,
  input  logic [7:0] prx_code_i,
  input  logic       prx_v_i,
  output logic [7:0] scan_code_o,
  output logic       scan_v_o
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam logic [TOW-1:0] TLIM = TOW'(TIMEOUT_US - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  localparam logic [7:0] CODE_ACK    = 8'hFA;
  localparam logic [7:0] CODE_RESEND = 8'hFE;
  localparam logic [7:0] CODE_TOUT   = 8'h00;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_RESP, DONE} state_t;

  state_t         state, state_d;
  logic [7:0]     cmd_q, cmd_d, arg_q, arg_d, res_q, res_d;
  logic           has_arg_q, has_arg_d, sel_arg, sel_arg_d;
  logic [RW-1:0]  retry, retry_d;
  logic [TOW-1:0] tcnt, tcnt_d, tcnt_inc_c;
  logic           tout_c;
  logic           busy_d, status_v_d, ptx_v_d, scan_v_d;
  logic [7:0]     status_d, ptx_code_d, scan_code_d;

  // Saturating microsecond counter; expiry fires on the pulse that reaches TIMEOUT_US.
  assign tcnt_inc_c = (tcnt == '1) ? tcnt : tcnt + TOW'(1);
  assign tout_c     = ck1us && (tcnt >= TLIM);

  always_comb begin
    state_d     = state;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    has_arg_d   = has_arg_q;
    sel_arg_d   = sel_arg;
    retry_d     = retry;
    tcnt_d      = tcnt;
    res_d       = res_q;
    busy_d      = cmd_busy_o;
    status_d    = status_o;
    status_v_d  = 1'b0;
    ptx_code_d  = ptx_code_o;
    ptx_v_d     = 1'b0;
    scan_code_d = scan_code_o;
    scan_v_d    = 1'b0;

    // Responses are consumed only while a reply is awaited.
    if (prx_v_i && (state != WAIT_RESP)) begin
      scan_v_d    = 1'b1;
      scan_code_d = prx_code_i;
    end

    case (state)
      IDLE: begin
        if (cmd_v_i) begin
          cmd_d     = cmd_i;
          arg_d     = arg_i;
          has_arg_d = has_arg_i;
          sel_arg_d = 1'b0;
          retry_d   = '0;
          busy_d    = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (!pbusy_i) begin
          ptx_v_d    = 1'b1;
          ptx_code_d = sel_arg ? arg_q : cmd_q;
          retry_d    = retry + RW'(1);
          tcnt_d     = '0;
          state_d    = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (ptx_acked_i) begin
          tcnt_d  = '0;
          state_d = WAIT_RESP;
        end else if (ptx_errd_i) begin
          if (retry < RMAX) begin
            state_d = SEND;
          end else begin
            res_d   = CODE_RESEND;
            state_d = DONE;
          end
        end else if (ck1us) begin
          tcnt_d = tcnt_inc_c;
          if (tout_c) begin
            res_d   = CODE_TOUT;
            state_d = DONE;
          end
        end
      end
      WAIT_RESP: begin
        if (prx_v_i) begin
          if (prx_code_i == CODE_ACK) begin
            if (!sel_arg && has_arg_q) begin
              sel_arg_d = 1'b1;
              retry_d   = '0;
              state_d   = SEND;
            end else begin
              res_d   = CODE_ACK;
              state_d = DONE;
            end
          end else if (prx_code_i == CODE_RESEND) begin
            if (retry < RMAX) begin
              state_d = SEND;
            end else begin
              res_d   = CODE_RESEND;
              state_d = DONE;
            end
          end else begin
            res_d   = prx_code_i;
            state_d = DONE;
          end
        end else if (ck1us) begin
          tcnt_d = tcnt_inc_c;
          if (tout_c) begin
            res_d   = CODE_TOUT;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        status_d   = res_q;
        status_v_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cmd_q       <= '0;
      arg_q       <= '0;
      has_arg_q   <= 1'b0;
      sel_arg     <= 1'b0;
      retry       <= '0;
      tcnt        <= '0;
      res_q       <= '0;
      cmd_busy_o  <= 1'b0;
      status_o    <= '0;
      status_v_o  <= 1'b0;
      ptx_code_o  <= '0;
      ptx_v_o     <= 1'b0;
      scan_code_o <= '0;
      scan_v_o    <= 1'b0;
    end else begin
      state       <= state_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      has_arg_q   <= has_arg_d;
      sel_arg     <= sel_arg_d;
      retry       <= retry_d;
      tcnt        <= tcnt_d;
      res_q       <= res_d;
      cmd_busy_o  <= busy_d;
      status_o    <= status_d;
      status_v_o  <= status_v_d;
      ptx_code_o  <= ptx_code_d;
      ptx_v_o     <= ptx_v_d;
      scan_code_o <= scan_code_d;
      scan_v_o    <= scan_v_d;
    end
  end

endmodule
